// File: rtl/mont_mul_serial_if.sv
// Start/ready_next handshake bundle between the exponentiation controller and
// one bit-serial Montgomery multiplier.
interface mont_mul_serial_if #(
    parameter int DATA_WIDTH = 1025
);
    logic                  ce;
    logic                  start;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic [DATA_WIDTH-1:0] n;
    logic                  busy;
    logic                  ready_next;
    logic                  ready;
    logic [DATA_WIDTH-1:0] result;

    modport master (
        output ce, start, a, b, n,
        input  busy, ready_next, ready, result
    );

    modport slave (
        input  ce, start, a, b, n,
        output busy, ready_next, ready, result
    );
endinterface

// File: rtl/mont_mul_serial.sv
// Bit-serial radix-2 Montgomery multiplier: result = A*B*2^-DATA_WIDTH mod N,
// left unreduced in [0, 2N) for the downstream final-addition stage.
module mont_mul_serial #(
    parameter int DATA_WIDTH = 1025
) (
    input logic              clk,
    input logic              rst,
    mont_mul_serial_if.slave mul_if
);
    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(DATA_WIDTH - 1);

    typedef enum logic {IDLE, RUN} state_e;

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH+1:0] s_q, s_d;
    logic [DATA_WIDTH-1:0] a_q, b_q, n_q;
    logic [DATA_WIDTH-1:0] result_q;
    logic                  ready_q;
    logic                  lastIter;

    logic [DATA_WIDTH+1:0] tSum;
    logic [DATA_WIDTH+1:0] tPrime;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else if (mul_if.ce) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (mul_if.start) state_d = RUN;
            RUN:  if (lastIter)     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ready_next comes from registered state only so the controller can
    // issue its next start without a combinational loop through this unit.
    always_comb begin
        lastIter          = (state_q == RUN) && (cnt_q == LAST_CNT);
        mul_if.busy       = (state_q == RUN);
        mul_if.ready_next = lastIter;
        mul_if.ready      = ready_q;
        mul_if.result     = result_q;
    end

    // One Montgomery step: conditionally add B, then add N if odd so the
    // halving is exact.
    always_comb begin
        tSum   = s_q + (a_q[cnt_q] ? {2'b00, b_q} : '0);
        tPrime = tSum + (tSum[0] ? {2'b00, n_q} : '0);
        s_d    = tPrime >> 1;
        cnt_d  = lastIter ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            s_q      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            n_q      <= '0;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else if (mul_if.ce) begin
            ready_q <= lastIter;
            if (state_q == IDLE) begin
                if (mul_if.start) begin
                    a_q   <= mul_if.a;
                    b_q   <= mul_if.b;
                    n_q   <= mul_if.n;
                    s_q   <= '0;
                    cnt_q <= '0;
                end
            end else begin
                s_q   <= s_d;
                cnt_q <= cnt_d;
                if (lastIter) result_q <= s_d[DATA_WIDTH-1:0];
            end
        end
    end
endmodule

// File: tb/tb_mont_mul_serial.sv
// Directed bench for mont_mul_serial at DATA_WIDTH=8: back-to-back vector
// table plus clock-enable, ignored-start and mid-run reset sequences.
module tb_mont_mul_serial;
    localparam int W = 8;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] n;
        logic [W-1:0] expResult;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   passed = 0;

    mont_mul_serial_if #(.DATA_WIDTH(W)) mulBus ();

    mont_mul_serial #(.DATA_WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .mul_if (mulBus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int unsigned actual, input int unsigned expected);
        checks++;
        if (actual == expected) passed++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    // Pulses start for one cycle; on return the DUT is in cycle 1 of the op.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] n);
        mulBus.ce    = 1'b1;
        mulBus.a     = a;
        mulBus.b     = b;
        mulBus.n     = n;
        mulBus.start = 1'b1;
        tick();
        mulBus.start = 1'b0;
    endtask

    // Watches an op until ready (bounded); optionally re-pulses start mid-run.
    task automatic watchOp(input int injectCycle, input logic [W-1:0] prevResult,
                           output int lat, output int busyCnt, output int rnCnt,
                           output int rnCycle, output int heldBad);
        lat = 0; busyCnt = 0; rnCnt = 0; rnCycle = 0; heldBad = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (mulBus.busy) busyCnt++;
            if (mulBus.ready_next) begin
                rnCnt++;
                rnCycle = cyc;
            end
            if (mulBus.ready) begin
                lat = cyc;
                break;
            end
            if (mulBus.result != prevResult) heldBad++;
            if (cyc == injectCycle) begin
                mulBus.start = 1'b1;
                mulBus.a     = 8'd25;
                mulBus.b     = 8'd25;
            end else begin
                mulBus.start = 1'b0;
            end
            tick();
        end
        mulBus.start = 1'b0;
    endtask

    initial begin
        vec_t vecs[6];
        int lat, busyCnt, rnCnt, rnCycle, heldBad;
        int ceHigh, unstable;
        logic [W-1:0] prev;
        logic [W+2:0] snap;

        vecs[0] = '{a: 8'd5,  b: 8'd7,  n: 8'd13, expResult: 8'd1};
        vecs[1] = '{a: 8'd25, b: 8'd25, n: 8'd13, expResult: 8'd3};
        vecs[2] = '{a: 8'd0,  b: 8'd25, n: 8'd13, expResult: 8'd0};
        vecs[3] = '{a: 8'd1,  b: 8'd1,  n: 8'd13, expResult: 8'd3};
        vecs[4] = '{a: 8'd7,  b: 8'd5,  n: 8'd13, expResult: 8'd1};
        vecs[5] = '{a: 8'd10, b: 8'd3,  n: 8'd11, expResult: 8'd10};

        rst = 1'b1;
        mulBus.ce = 1'b0;
        mulBus.start = 1'b0;
        mulBus.a = '0;
        mulBus.b = '0;
        mulBus.n = '0;
        tick();
        tick();
        checkOutput("reset busy", mulBus.busy, 0);
        checkOutput("reset ready_next", mulBus.ready_next, 0);
        checkOutput("reset ready", mulBus.ready, 0);
        checkOutput("reset result", mulBus.result, 0);
        rst = 1'b0;
        tick();

        // Each new start lands in the ready cycle of the previous op.
        prev = '0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].n);
            watchOp(0, prev, lat, busyCnt, rnCnt, rnCycle, heldBad);
            checkOutput($sformatf("vec%0d latency", i), lat, 9);
            checkOutput($sformatf("vec%0d busy cycles", i), busyCnt, 8);
            checkOutput($sformatf("vec%0d ready_next count", i), rnCnt, 1);
            checkOutput($sformatf("vec%0d ready_next cycle", i), rnCycle, 8);
            checkOutput($sformatf("vec%0d result held", i), heldBad, 0);
            checkOutput($sformatf("vec%0d result", i), mulBus.result, vecs[i].expResult);
            prev = vecs[i].expResult;
        end

        // ce toggling during RUN: only ce-high cycles make progress.
        applyStimulus(8'd5, 8'd7, 8'd13);
        ceHigh = 0;
        unstable = 0;
        for (int it = 0; it < 40; it++) begin
            if (mulBus.ready) break;
            mulBus.ce = (it % 2 == 0) ? 1'b0 : 1'b1;
            snap = {mulBus.busy, mulBus.ready_next, mulBus.ready, mulBus.result};
            tick();
            if (!mulBus.ce && snap != {mulBus.busy, mulBus.ready_next, mulBus.ready, mulBus.result})
                unstable++;
            if (mulBus.ce) ceHigh++;
        end
        mulBus.ce = 1'b1;
        checkOutput("ce toggle ready", mulBus.ready, 1);
        checkOutput("ce toggle high cycles", ceHigh, 8);
        checkOutput("ce toggle stable when low", unstable, 0);
        checkOutput("ce toggle result", mulBus.result, 1);

        // start re-pulsed mid-run with other operands must be ignored.
        applyStimulus(8'd5, 8'd7, 8'd13);
        watchOp(3, 8'd1, lat, busyCnt, rnCnt, rnCycle, heldBad);
        checkOutput("ignored start latency", lat, 9);
        checkOutput("ignored start result", mulBus.result, 1);
        tick();
        checkOutput("ignored start no restart", mulBus.busy, 0);

        // Reset in cycle 4 aborts the run and clears the held result.
        applyStimulus(8'd25, 8'd25, 8'd13);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("abort busy", mulBus.busy, 0);
        checkOutput("abort ready_next", mulBus.ready_next, 0);
        checkOutput("abort ready", mulBus.ready, 0);
        checkOutput("abort result", mulBus.result, 0);
        applyStimulus(8'd5, 8'd7, 8'd13);
        watchOp(0, 8'd0, lat, busyCnt, rnCnt, rnCycle, heldBad);
        checkOutput("after abort latency", lat, 9);
        checkOutput("after abort result", mulBus.result, 1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
